// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the VGA frame-buffer arbiter:
// CPU-port FSM encoding, read-tag layout and owner codes.
package vga_fb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_ACK     = 2'd3
  } cpu_state_e;

  localparam logic OWN_DISP = 1'b0;
  localparam logic OWN_CPU  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/vga_fb_tag_pipe.sv
// Two-stage read-tag shift register. It follows each RAM read to the edge
// where its data is on mem_rdata, and raises the capture enable for that owner.
module vga_fb_tag_pipe
  import vga_fb_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  tag_t i_tag,
  output logic o_disp_cap,
  output logic o_cpu_cap
);

  tag_t r_stage0;
  tag_t r_stage1;

  // Shift the tags every edge; reset drops any read that is in flight.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_stage0 <= '0;
      r_stage1 <= '0;
    end else begin
      r_stage0 <= i_tag;
      r_stage1 <= r_stage0;
    end
  end

  // Stage 1 lines up with the edge where the RAM data can be captured.
  always_comb begin
    o_disp_cap = r_stage1.valid && (r_stage1.owner == OWN_DISP);
    o_cpu_cap  = r_stage1.valid && (r_stage1.owner == OWN_CPU);
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter. Display fetches have strict priority and a fixed
// 2-clock latency; CPU accesses use a req/ack handshake and fill idle slots.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int STALL_W = 16
)
(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_disp_req,
  input  logic [ADDR_W-1:0]  i_disp_addr,
  output logic [DATA_W-1:0]  o_disp_rdata,
  output logic               o_disp_valid,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [ADDR_W-1:0]  i_cpu_addr,
  input  logic [DATA_W-1:0]  i_cpu_wdata,
  output logic [DATA_W-1:0]  o_cpu_rdata,
  output logic               o_cpu_ack,
  output logic               o_mem_en,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  input  logic               i_stat_clr,
  output logic [STALL_W-1:0] o_cpu_stall_cnt,
  output logic               o_disp_overrun
);

  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  cpu_state_e         r_state;
  cpu_state_e         w_next_state;
  logic               w_cpu_issue;
  logic               w_stall_evt;
  logic               w_ovr_evt;
  logic               w_disp_cap;
  logic               w_cpu_cap;
  tag_t               w_tag;

  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  r_disp_rdata;
  logic               r_disp_valid;
  logic [DATA_W-1:0]  r_cpu_rdata;
  logic               r_cpu_ack;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_overrun;
  logic               r_disp_req_d;

  // CPU FSM state register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration, next-state and event decode; a display request always wins the slot.
  always_comb begin
    w_next_state = r_state;
    w_cpu_issue  = 1'b0;
    w_stall_evt  = 1'b0;
    w_tag        = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_cpu_req) begin
          if (i_disp_req) begin
            w_stall_evt = 1'b1;
          end else begin
            w_cpu_issue  = 1'b1;
            w_next_state = i_cpu_we ? ST_ACK : ST_RD_WAIT;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD_WAIT: w_next_state = ST_RD_DATA;
      ST_RD_DATA: w_next_state = ST_ACK;
      ST_ACK:     w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
    w_tag.valid = i_disp_req | (w_cpu_issue & ~i_cpu_we);
    w_tag.owner = i_disp_req ? OWN_DISP : OWN_CPU;
    w_ovr_evt   = i_disp_req & r_disp_req_d;
  end

  vga_fb_tag_pipe u_tag_pipe (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_tag      (w_tag),
    .o_disp_cap (w_disp_cap),
    .o_cpu_cap  (w_cpu_cap)
  );

  // RAM command registers and read-data capture for both requesters.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_disp_rdata <= '0;
      r_disp_valid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_ack    <= 1'b0;
    end else begin
      r_mem_en <= i_disp_req | w_cpu_issue;
      r_mem_we <= ~i_disp_req & w_cpu_issue & i_cpu_we;
      if (i_disp_req) begin
        r_mem_addr <= i_disp_addr;
      end else if (w_cpu_issue) begin
        r_mem_addr  <= i_cpu_addr;
        r_mem_wdata <= i_cpu_wdata;
      end else begin
        r_mem_addr <= r_mem_addr;
      end
      r_disp_valid <= w_disp_cap;
      if (w_disp_cap) begin
        r_disp_rdata <= i_mem_rdata;
      end else begin
        r_disp_rdata <= r_disp_rdata;
      end
      if (w_cpu_cap) begin
        r_cpu_rdata <= i_mem_rdata;
      end else begin
        r_cpu_rdata <= r_cpu_rdata;
      end
      // The ack pulse follows the ACK state by one edge.
      r_cpu_ack <= (r_state == ST_ACK);
    end
  end

  // Statistics: saturating stall counter and sticky overrun; a clear beats any event.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_stall_cnt  <= '0;
      r_overrun    <= 1'b0;
      r_disp_req_d <= 1'b0;
    end else begin
      r_disp_req_d <= i_disp_req;
      if (i_stat_clr) begin
        r_stall_cnt <= '0;
        r_overrun   <= 1'b0;
      end else begin
        if (w_stall_evt && (r_stall_cnt != STALL_MAX)) begin
          r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end else begin
          r_stall_cnt <= r_stall_cnt;
        end
        r_overrun <= r_overrun | w_ovr_evt;
      end
    end
  end

  assign o_mem_en        = r_mem_en;
  assign o_mem_we        = r_mem_we;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_disp_rdata    = r_disp_rdata;
  assign o_disp_valid    = r_disp_valid;
  assign o_cpu_rdata     = r_cpu_rdata;
  assign o_cpu_ack       = r_cpu_ack;
  assign o_cpu_stall_cnt = r_stall_cnt;
  assign o_disp_overrun  = r_overrun;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural sync RAM and a
// scoreboard that checks returned data and its arrival cycle.
module tb_vga_fb_arbiter;

  logic        clk;
  logic        reset;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic [7:0]  disp_rdata;
  logic        disp_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        stat_clr;
  logic [15:0] stall_cnt;
  logic        overrun;

  typedef struct {
    logic [7:0] data;
    int         due;
    logic       rd;
  } exp_t;

  exp_t disp_q[$];
  exp_t cpu_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [7:0] ram [0:65535];
  logic       ram_init_done = 1'b0;

  vga_fb_arbiter dut (
    .i_clock         (clk),
    .i_reset         (reset),
    .i_disp_req      (disp_req),
    .i_disp_addr     (disp_addr),
    .o_disp_rdata    (disp_rdata),
    .o_disp_valid    (disp_valid),
    .i_cpu_req       (cpu_req),
    .i_cpu_we        (cpu_we),
    .i_cpu_addr      (cpu_addr),
    .i_cpu_wdata     (cpu_wdata),
    .o_cpu_rdata     (cpu_rdata),
    .o_cpu_ack       (cpu_ack),
    .o_mem_en        (mem_en),
    .o_mem_we        (mem_we),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .i_mem_rdata     (mem_rdata),
    .i_stat_clr      (stat_clr),
    .o_cpu_stall_cnt (stall_cnt),
    .o_disp_overrun  (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM, preloaded with data = addr[7:0].
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int a = 0; a < 65536; a++) ram[a] <= a[7:0];
      mem_rdata     <= 8'h00;
      ram_init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on each output pulse, compare data and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (disp_valid) begin
      if (disp_q.size() == 0) begin
        check("disp_unexpected", 64'd1, 64'd0);
      end else begin
        e = disp_q.pop_front();
        check("disp_data", disp_rdata, e.data);
        check("disp_latency", cyc, e.due);
      end
    end
    if (cpu_ack) begin
      if (cpu_q.size() == 0) begin
        check("cpu_unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = cpu_q.pop_front();
        if (e.rd) check("cpu_rdata", cpu_rdata, e.data);
        check("cpu_ack_latency", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_disp(input logic [7:0] d);
    exp_t e;
    e.data = d; e.due = cyc + 2; e.rd = 1'b1;
    disp_q.push_back(e);
  endtask

  task automatic push_cpu(input logic rd, input logic [7:0] d);
    exp_t e;
    e.data = d; e.due = cyc + (rd ? 3 : 1); e.rd = rd;
    cpu_q.push_back(e);
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (!cpu_ack && n < 10) begin
      tick();
      n++;
    end
    check("cpu_ack_timeout", cpu_ack, 1'b1);
    cpu_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; disp_req = 1'b0; disp_addr = 16'h0000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 8'h00;
    stat_clr = 1'b0;

    // Reset held with traffic present: everything must stay quiet.
    for (int i = 0; i < 3; i++) begin
      disp_req = (i != 1);
      disp_addr = 16'h0003;
      tick();
      check("reset_outputs", {mem_en, mem_we, mem_addr, mem_wdata, disp_rdata, disp_valid,
                              cpu_rdata, cpu_ack, stall_cnt, overrun}, 64'd0);
    end
    reset = 1'b1; disp_req = 1'b0;
    tick();
    check("release_issue_en", mem_en, 1'b1);
    check("release_issue_addr", mem_addr, 16'h0010);
    push_cpu(1'b1, 8'h10);
    wait_ack();

    // Display-only scan at half rate.
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = i[15:0];
      tick();
      check("disp_issue_addr", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, i[15:0]});
      push_disp(i[7:0]);
      disp_req = 1'b0;
      tick();
    end
    tick(); tick();
    check("no_overrun_half_rate", overrun, 1'b0);

    // CPU write then read-back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
    tick();
    check("cpu_wr_issue", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h1234, 8'hA5});
    push_cpu(1'b0, 8'h00);
    wait_ack();
    tick();
    check("ram_written", ram[16'h1234], 8'hA5);
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    check("cpu_rd_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h1234});
    push_cpu(1'b1, 8'hA5);
    wait_ack();

    // Contention: display wins, CPU follows, display interleaves with the CPU read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    disp_req = 1'b1; disp_addr = 16'h0100;
    tick();
    check("contend_disp_first", mem_addr, 16'h0100);
    check("contend_stall", stall_cnt, 16'd1);
    push_disp(8'h00);
    disp_req = 1'b0;
    tick();
    check("contend_cpu_next", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0040});
    push_cpu(1'b1, 8'h40);
    disp_req = 1'b1; disp_addr = 16'h0105;
    tick();
    check("disp_during_rdwait", {mem_en, mem_addr}, {1'b1, 16'h0105});
    push_disp(8'h05);
    disp_req = 1'b0;
    wait_ack();
    check("stall_unchanged", stall_cnt, 16'd1);

    // Back-to-back display requests set the sticky overrun.
    disp_req = 1'b1; disp_addr = 16'h0020;
    tick();
    push_disp(8'h20);
    disp_addr = 16'h0021;
    tick();
    push_disp(8'h21);
    disp_req = 1'b0;
    check("overrun_set", overrun, 1'b1);
    tick(); tick();
    check("overrun_sticky", overrun, 1'b1);

    // Clear coincides with a stall event: clear wins.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
    disp_req = 1'b1; disp_addr = 16'h0030; stat_clr = 1'b1;
    tick();
    check("clr_stall", stall_cnt, 16'd0);
    check("clr_overrun", overrun, 1'b0);
    push_disp(8'h30);
    disp_req = 1'b0; stat_clr = 1'b0;
    tick();
    check("clr_cpu_issue", mem_addr, 16'h0050);
    push_cpu(1'b1, 8'h50);
    wait_ack();

    // Reset while the CPU read is in RD_DATA: the read is dropped.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0060;
    tick();
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    tick();
    check("midrst_rdata", cpu_rdata, 8'h00);
    check("midrst_ack", cpu_ack, 1'b0);
    reset = 1'b1;
    tick(); tick(); tick();
    check("midrst_no_late_ack", cpu_ack, 1'b0);
    cpu_req = 1'b1; cpu_addr = 16'h0061;
    tick();
    check("post_rst_issue", {mem_en, mem_addr}, {1'b1, 16'h0061});
    push_cpu(1'b1, 8'h61);
    wait_ack();

    for (int i = 0; i < 5; i++) tick();
    check("disp_queue_drained", disp_q.size(), 0);
    check("cpu_queue_drained", cpu_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
